// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Receive-side checker for a divided clock (nominally EXP_PERIOD clk cycles).
// The divided clock is synchronised into the clk domain, its period and high
// time are measured in clk cycles, and a lock indication is raised once
// LOCK_CNT consecutive periods fall within EXP_PERIOD +/- TOL. Loss of the
// divided clock (no rising edge for TIMEOUT cycles) raises a sticky flag.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   asynchronous, active-high reset
//   sig_in     in   divided clock under test, asynchronous to clk
//   period     out  last measured period in clk cycles
//   high_time  out  high time of the last measured period in clk cycles
//   meas_valid out  single-cycle pulse when period/high_time update
//   locked     out  period has been stable within tolerance
//   timeout    out  sticky loss flag, cleared by the next rising edge
// -----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int CNT_W      = 12,
    parameter int EXP_PERIOD = 625,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 2047
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] GOOD_LO   = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] GOOD_HI   = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        RUN
    } state_t;

    state_t state, state_next;

    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] pcnt, hcnt, hlat;
    logic [3:0]       good_cnt;
    logic [3:0]       good_cnt_inc;
    logic             period_good;
    logic             publish;
    logic             lost;

    // Three-flop synchroniser. s1 may go metastable; edges are taken from
    // s2/s3 so every edge sees the same fixed latency and the measured
    // differences are exact.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Period and high-time counters, both restarting at 1 on a rise and
    // saturating rather than wrapping so a dead input cannot alias to a
    // plausible period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            hcnt <= '0;
            hlat <= '0;
        end else begin
            if (rise)
                pcnt <= CNT_ONE;
            else if (pcnt != CNT_MAX)
                pcnt <= pcnt + CNT_ONE;

            if (rise)
                hcnt <= CNT_ONE;
            else if (s2 && (hcnt != CNT_MAX))
                hcnt <= hcnt + CNT_ONE;

            if (fall)
                hlat <= hcnt;
        end
    end

    assign period_good  = (pcnt >= GOOD_LO) && (pcnt <= GOOD_HI);
    assign good_cnt_inc = (good_cnt >= LOCK_C) ? LOCK_C : good_cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A rise takes priority over the timeout compare, so a period of exactly
    // TIMEOUT cycles is still published as a measurement.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        publish    = 1'b0;
        lost       = 1'b0;
        case (state)
            IDLE: begin
                if (rise)
                    state_next = FIRST;
            end
            FIRST, RUN: begin
                if (rise) begin
                    state_next = RUN;
                    publish    = 1'b1;
                end else if (pcnt == TIMEOUT_C) begin
                    state_next = IDLE;
                    lost       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            good_cnt   <= '0;
        end else begin
            meas_valid <= publish;

            if (publish) begin
                period    <= pcnt;
                high_time <= hlat;
                if (period_good) begin
                    good_cnt <= good_cnt_inc;
                    locked   <= (good_cnt_inc == LOCK_C);
                end else begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            end

            if (lost) begin
                timeout  <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
            end

            if ((state == IDLE) && rise)
                timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//
// Drives sig_in as a sequence of (high, low) durations in clk cycles. A
// reference model works purely on those durations: the measurement published
// at each rise is the previous period's length and high time, a gap longer
// than TIMEOUT means loss, and lock means a run of LOCK_CNT good periods.
// Expected measurements are queued at each rise; a monitor pops and compares
// whenever meas_valid is seen.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int CNT_W      = 12;
    localparam int EXP_PERIOD = 625;
    localparam int TOL        = 2;
    localparam int LOCK_CNT   = 4;
    localparam int TIMEOUT    = 2047;

    logic             clk;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK_CNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
        int l;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: previous period's durations and the current
    // run of consecutive good periods.
    bit   have_prev = 0;
    int   prev_p    = 0;
    int   prev_h    = 0;
    int   good_run  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at the instant sig_in rises; h/p describe the period starting now.
    task automatic model_rise(input int h, input int p);
        exp_t e;
        int   dev;
        if (have_prev) begin
            if (prev_p > TIMEOUT) begin
                good_run = 0;
            end else begin
                dev = prev_p - EXP_PERIOD;
                if (dev < 0) dev = -dev;
                good_run = (dev <= TOL) ? good_run + 1 : 0;
                e.p = prev_p;
                e.h = prev_h;
                e.l = (good_run >= LOCK_CNT) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
        have_prev = 1;
        prev_h    = h;
        prev_p    = p;
    endtask

    // Starts and ends on a falling clk edge.
    task automatic run_period(input int h, input int l);
        sig_in = 1'b1;
        model_rise(h, h + l);
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && meas_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_meas: got period %0d, expected no measurement at %0t",
                         period, $time);
            end else begin
                e = exp_q.pop_front();
                check("period",    int'(period),    e.p);
                check("high_time", int'(high_time), e.h);
                check("locked",    int'(locked),    e.l);
            end
        end
    end

    initial begin
        int p;
        int h;

        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period",     int'(period),     0);
        check("rst_high_time",  int'(high_time),  0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_locked",     int'(locked),     0);
        check("rst_timeout",    int'(timeout),    0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Nominal lock.
        repeat (6) run_period(312, 313);
        check("nominal_locked", int'(locked), 1);

        // Tolerance edges: 627 keeps lock, one 628 drops it, then relock.
        repeat (3) run_period(313, 314);
        run_period(314, 314);
        repeat (5) run_period(312, 313);

        // Duty capture.
        repeat (2) run_period(313, 312);
        repeat (2) run_period(1, 624);
        run_period(312, 313);
        check("duty_locked", int'(locked), 1);

        // Loss of clock: one rise, then held low. Timeout must appear exactly
        // on the 2050th falling edge after the rise was driven.
        sig_in = 1'b1;
        model_rise(312, 2512);
        for (int k = 1; k <= 2512; k++) begin
            @(negedge clk);
            if (k == 312) sig_in = 1'b0;
            if (k == 2049) begin
                check("loss_timeout_early", int'(timeout), 0);
                check("loss_locked_early",  int'(locked),  1);
            end
            if (k == 2050) begin
                check("loss_timeout", int'(timeout), 1);
                check("loss_locked",  int'(locked),  0);
                check("loss_period",  int'(period),  625);
            end
        end
        check("loss_timeout_sticky", int'(timeout), 1);

        // Resume toggling.
        run_period(312, 313);
        check("resume_timeout_clear", int'(timeout), 0);
        repeat (5) run_period(312, 313);

        // Rise coincident with the timeout compare.
        run_period(1000, 1047);
        run_period(312, 313);
        check("coincident_timeout", int'(timeout), 0);

        // Reset mid-measurement, while the input is low.
        sig_in = 1'b1;
        model_rise(200, 625);
        repeat (200) @(negedge clk);
        sig_in = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_period",     int'(period),     0);
        check("midrst_high_time",  int'(high_time),  0);
        check("midrst_meas_valid", int'(meas_valid), 0);
        check("midrst_locked",     int'(locked),     0);
        @(negedge clk);
        rst       = 1'b0;
        have_prev = 0;
        good_run  = 0;
        repeat (324) @(negedge clk);
        repeat (6) run_period(312, 313);

        // Randomised periods around the tolerance window.
        repeat (30) begin
            p = EXP_PERIOD - 4 + int'($urandom_range(0, 8));
            h = int'($urandom_range(1, p - 1));
            run_period(h, p - h);
        end

        // Final rise closes the last period.
        sig_in = 1'b1;
        model_rise(10, 20);
        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side checker for the odd-ratio divided clocks produced by the team's divide-by-625 generator.
- Samples a divided clock (nominal 625 clk cycles) as an asynchronous input.
- Measures its period and high time in clk cycles and asserts lock once the period is stable within tolerance.
- Flags loss of the divided clock. Sits beside the divider and feeds status/debug registers.

Parameters:
- CNT_W, 12: width of the period/high-time counters and outputs.
- EXP_PERIOD, 625: expected period in clk cycles.
- TOL, 2: allowed ± deviation from EXP_PERIOD for a "good" period.
- LOCK_CNT, 4: consecutive good periods needed to assert locked (range 1..15).
- TIMEOUT, 2047: cycles without a rising edge before loss is declared. Must be < 2^CNT_W-1.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- sig_in, input, 1: divided clock under test, asynchronous to clk.
- period, output, CNT_W: last measured period in clk cycles.
- high_time, output, CNT_W: high time of the last measured period in clk cycles.
- meas_valid, output, 1: single-cycle pulse when period/high_time update.
- locked, output, 1: period has been stable within tolerance.
- timeout, output, 1: sticky loss flag; cleared by the next rising edge.

Behaviour:
- Reset (asynchronous, active-high):
  - Sync flops s1/s2/s3 = 0.
  - period = 0, high_time = 0, meas_valid = 0, locked = 0, timeout = 0.
  - Counters = 0, good-count = 0, state = IDLE.
- Synchroniser and edge detect:
  - sig_in → s1 → s2 → s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Fixed 3-cycle detection latency, so measured differences are exact.
- Period counter pcnt:
  - Loaded to 1 on rise; otherwise increments.
  - Saturates at 2^CNT_W-1 (no wrap).
- High counter hcnt:
  - Loaded to 1 on rise; increments while s2 = 1.
  - On fall, hcnt is latched into internal hlat.
- States:
  - IDLE: waiting for first rise. On rise → FIRST, clear timeout.
  - FIRST: one rise seen, no complete period yet.
    - On rise → RUN and publish a measurement.
    - On pcnt == TIMEOUT → IDLE.
  - RUN: on every rise:
    - period <= pcnt, high_time <= hlat, meas_valid = 1 for exactly that cycle.
    - Good-count update (below).
    - On pcnt == TIMEOUT → IDLE.
- Timeout (reaching pcnt == TIMEOUT from FIRST or RUN):
  - timeout <= 1 and locked <= 0 in the same cycle.
  - good-count <= 0; period and high_time hold their last values.
  - A constant-high or constant-low input both time out.
- Lock:
  - A period is good if |pcnt − EXP_PERIOD| ≤ TOL.
  - Good period: good-count increments, saturating at LOCK_CNT. locked = 1 when good-count reaches LOCK_CNT, in the same cycle as that meas_valid.
  - Bad period: good-count <= 0 and locked <= 0 in the same cycle as meas_valid.
- Simultaneous events:
  - rise and pcnt == TIMEOUT in the same cycle: the rise wins. Measurement published, no timeout.
  - rise and fall cannot coincide.
- Reset mid-period: all state discarded. The first rise after reset produces no meas_valid.
- Outputs are registered. period/high_time change only in meas_valid cycles.

Test Plan:
- Nominal lock: after reset, sig_in with period 625 and high 312 → meas_valid starts at the 2nd rise with period = 625, high_time = 312; locked rises at the 5th rise (4th measurement).
- Tolerance edges:
  - Period 627 → stays locked.
  - One period of 628 → locked drops in that meas_valid cycle; relock after 4 further good periods.
- Duty capture: period 625, high 313 → high_time = 313. Swap to high 1 → high_time = 1.
- Loss of clock:
  - Hold sig_in low after lock → timeout = 1 and locked = 0 exactly 2047 cycles after the last detected rise; period stays 625.
  - Resume toggling → timeout clears on the first rise; the next meas_valid comes one period later.
- Reset mid-measurement: assert rst for 1 cycle at pcnt ≈ 300 → all outputs 0 immediately; no meas_valid until the 2nd rise after reset.
- Rise coincident with timeout: period exactly 2047 → meas_valid with period = 2047, timeout stays 0, locked = 0.
